// File: rtl/serial_divider_pkg.sv
// Shared types and constants for the serial divider scheduler.
package serial_divider_pkg;

    localparam int unsigned DefXlen = 32;
    localparam int unsigned DefNreq = 2;

    // Divide-by-zero quotient is all-ones; replicated to XLEN at the use site.
    localparam logic DzQuotientBit = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StBusy,
        StResp
    } sched_state_e;

endpackage

// File: rtl/serial_divider_sched_if.sv
// Requester and divider-core signals of the scheduler.
// slave: the scheduler; master: requester front-ends plus divider core.
interface serial_divider_sched_if
    import serial_divider_pkg::*;
#(
    parameter int unsigned XLEN = DefXlen,
    parameter int unsigned NREQ = DefNreq
);
    logic [NREQ-1:0]      req_i;
    logic [NREQ*XLEN-1:0] dividend_i;
    logic [NREQ*XLEN-1:0] divisor_i;
    logic [NREQ-1:0]      gnt_o;
    logic [NREQ-1:0]      done_o;
    logic [XLEN-1:0]      quotient_o;
    logic [XLEN-1:0]      remainder_o;
    logic                 dz_o;
    logic                 busy_o;
    logic                 div_start_o;
    logic [XLEN-1:0]      div_dividend_o;
    logic [XLEN-1:0]      div_divisor_o;
    logic                 div_fini_i;
    logic [XLEN-1:0]      div_quotient_i;
    logic [XLEN-1:0]      div_remainder_i;

    modport slave (
        input  req_i, dividend_i, divisor_i, div_fini_i, div_quotient_i, div_remainder_i,
        output gnt_o, done_o, quotient_o, remainder_o, dz_o, busy_o,
        output div_start_o, div_dividend_o, div_divisor_o
    );

    modport master (
        output req_i, dividend_i, divisor_i, div_fini_i, div_quotient_i, div_remainder_i,
        input  gnt_o, done_o, quotient_o, remainder_o, dz_o, busy_o,
        input  div_start_o, div_dividend_o, div_divisor_o
    );

endinterface

// File: rtl/serial_divider_rr_arbiter.sv
// One-hot round-robin picker; the requester after the last owner has top priority.
module serial_divider_rr_arbiter
    import serial_divider_pkg::*;
#(
    parameter int unsigned NREQ = DefNreq,
    localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [NREQ-1:0] req_i,
    input  logic            en_i,
    input  logic            update_i,
    input  logic [IdxW-1:0] last_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IdxW-1:0] idx_o,
    output logic            valid_o
);
    logic [IdxW-1:0] last_q;
    logic [IdxW-1:0] cand;

    // Last owner; reset to the top index so requester 0 wins first.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            last_q <= IdxW'(NREQ - 1);
        end else if (update_i) begin
            last_q <= last_i;
        end
    end

    // Scan from the requester after last_q, first requesting one wins.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        if (en_i) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                cand = IdxW'((32'(last_q) + 32'd1 + i) % NREQ);
                if (!valid_o && req_i[cand]) begin
                    valid_o     = 1'b1;
                    idx_o       = cand;
                    gnt_o[cand] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/serial_divider_sched.sv
// Shares one serial divider core between NREQ requesters; handles divide-by-zero locally.
module serial_divider_sched
    import serial_divider_pkg::*;
#(
    parameter int unsigned XLEN = DefXlen,
    parameter int unsigned NREQ = DefNreq
) (
    input logic                   clk_i,
    input logic                   reset_i,
    serial_divider_sched_if.slave sched_io
);
    localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

    sched_state_e    state_q;
    logic [IdxW-1:0] owner_q;
    logic [XLEN-1:0] dividend_q;
    logic [XLEN-1:0] divisor_q;
    logic [XLEN-1:0] quotient_q;
    logic [XLEN-1:0] remainder_q;
    logic            dz_q;
    logic            start_q;
    logic [NREQ-1:0] done_q;

    logic [NREQ-1:0] arb_gnt;
    logic [IdxW-1:0] arb_idx;
    logic            arb_valid;
    logic [XLEN-1:0] sel_dividend;
    logic [XLEN-1:0] sel_divisor;

    serial_divider_rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .req_i    (sched_io.req_i),
        .en_i     (state_q == StIdle),
        .update_i (state_q == StResp),
        .last_i   (owner_q),
        .gnt_o    (arb_gnt),
        .idx_o    (arb_idx),
        .valid_o  (arb_valid)
    );

    assign sel_dividend = sched_io.dividend_i[arb_idx*XLEN +: XLEN];
    assign sel_divisor  = sched_io.divisor_i[arb_idx*XLEN +: XLEN];

    // Sequencer: grant/capture, start pulse, wait for finish, one-cycle done.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            owner_q     <= '0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dz_q        <= 1'b0;
            start_q     <= 1'b0;
            done_q      <= '0;
        end else begin
            start_q <= 1'b0;
            done_q  <= '0;
            unique case (state_q)
                StIdle: begin
                    if (arb_valid) begin
                        owner_q    <= arb_idx;
                        dividend_q <= sel_dividend;
                        divisor_q  <= sel_divisor;
                        if (sel_divisor == '0) begin
                            // Resolve locally, the divider core is never started.
                            quotient_q  <= {XLEN{DzQuotientBit}};
                            remainder_q <= sel_dividend;
                            dz_q        <= 1'b1;
                            done_q      <= NREQ'(1) << arb_idx;
                            state_q     <= StResp;
                        end else begin
                            start_q <= 1'b1;
                            state_q <= StStart;
                        end
                    end
                end
                // A finish pulse seen while starting is stale and dropped.
                StStart: state_q <= StBusy;
                StBusy: begin
                    if (sched_io.div_fini_i) begin
                        quotient_q  <= sched_io.div_quotient_i;
                        remainder_q <= sched_io.div_remainder_i;
                        dz_q        <= 1'b0;
                        done_q      <= NREQ'(1) << owner_q;
                        state_q     <= StResp;
                    end
                end
                StResp: state_q <= StIdle;
            endcase
        end
    end

    assign sched_io.gnt_o          = arb_gnt;
    assign sched_io.done_o         = done_q;
    assign sched_io.quotient_o     = quotient_q;
    assign sched_io.remainder_o    = remainder_q;
    assign sched_io.dz_o           = dz_q;
    assign sched_io.busy_o         = (state_q != StIdle);
    assign sched_io.div_start_o    = start_q;
    assign sched_io.div_dividend_o = dividend_q;
    assign sched_io.div_divisor_o  = divisor_q;

endmodule

// File: tb/tb_serial_divider_sched.sv
// Bench for serial_divider_sched with a latency-programmable divider stub.
module tb_serial_divider_sched;
    localparam int unsigned XLEN = 32;
    localparam int unsigned NREQ = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   exp_last = NREQ - 1;
    logic [XLEN-1:0] hold_q = '0;

    // Divider stub: fini in cycle start+L; optional stale fini during START.
    int          stub_lat = 1;
    logic        stub_spur = 1'b0;
    logic        stub_act;
    int          stub_cnt;
    logic [31:0] stub_a, stub_b;

    serial_divider_sched_if #(.XLEN(XLEN), .NREQ(NREQ)) bus ();

    serial_divider_sched #(
        .XLEN (XLEN),
        .NREQ (NREQ)
    ) dut (
        .clk_i    (clk),
        .reset_i  (rst),
        .sched_io (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            stub_act <= 1'b0;
            stub_cnt <= 0;
            stub_a   <= '0;
            stub_b   <= '0;
        end else if (bus.div_start_o) begin
            stub_act <= 1'b1;
            stub_cnt <= stub_lat;
            stub_a   <= bus.div_dividend_o;
            stub_b   <= bus.div_divisor_o;
        end else if (stub_act) begin
            if (stub_cnt <= 1) stub_act <= 1'b0;
            else stub_cnt <= stub_cnt - 1;
        end
    end

    wire stub_real = stub_act && (stub_cnt == 1);
    assign bus.div_fini_i      = stub_real || (stub_spur && bus.div_start_o);
    assign bus.div_quotient_i  = (stub_real && stub_b != 0) ? stub_a / stub_b : 32'hDEAD_BEEF;
    assign bus.div_remainder_i = (stub_real && stub_b != 0) ? stub_a % stub_b : 32'hBAD0_0BAD;

    // Reference round-robin: first requester after the last owner.
    function automatic int model_pick(input logic [NREQ-1:0] r, input int last);
        for (int i = 1; i <= int'(NREQ); i++) begin
            if (r[(last + i) % NREQ]) return (last + i) % NREQ;
        end
        return -1;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Advance until a done pulse is visible; cyc = -1 when the budget runs out.
    task automatic wait_done(input int budget, inout int cyc, output int starts, output int gnts);
        starts = 0;
        gnts = 0;
        for (int n = 0; n < budget; n++) begin
            if (bus.div_start_o) starts++;
            if (bus.gnt_o != '0) gnts++;
            if (bus.done_o != '0) return;
            tick();
            cyc++;
        end
        cyc = -1;
    endtask

    task automatic test_reset;
        bus.req_i = '0;
        bus.dividend_i = '0;
        bus.divisor_i = '0;
        rst = 1'b1;
        #12;
        checks++; if (bus.gnt_o !== 2'b00) begin errors++; $display("FAIL rst_gnt got %b want 00", bus.gnt_o); end
        checks++; if (bus.done_o !== 2'b00) begin errors++; $display("FAIL rst_done got %b want 00", bus.done_o); end
        checks++; if (bus.quotient_o !== 32'd0) begin errors++; $display("FAIL rst_quot got %h want 0", bus.quotient_o); end
        checks++; if (bus.remainder_o !== 32'd0) begin errors++; $display("FAIL rst_rem got %h want 0", bus.remainder_o); end
        checks++; if (bus.dz_o !== 1'b0) begin errors++; $display("FAIL rst_dz got %b want 0", bus.dz_o); end
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", bus.busy_o); end
        checks++; if (bus.div_start_o !== 1'b0) begin errors++; $display("FAIL rst_start got %b want 0", bus.div_start_o); end
        checks++; if (bus.div_dividend_o !== 32'd0) begin errors++; $display("FAIL rst_dvd got %h want 0", bus.div_dividend_o); end
        checks++; if (bus.div_divisor_o !== 32'd0) begin errors++; $display("FAIL rst_dvs got %h want 0", bus.div_divisor_o); end
        @(negedge clk);
        rst = 1'b0;
        exp_last = NREQ - 1;
        tick();
    endtask

    task automatic test_basic;
        int cyc, st, gn;
        stub_lat = 32;
        bus.dividend_i = {32'd0, 32'd100};
        bus.divisor_i = {32'd0, 32'd7};
        bus.req_i = 2'b01;
        #1;
        checks++; if (bus.gnt_o !== 2'b01) begin errors++; $display("FAIL basic_gnt got %b want 01", bus.gnt_o); end
        tick();
        cyc = 1;
        bus.req_i = '0;
        checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", bus.busy_o); end
        checks++; if (bus.div_dividend_o !== 32'd100) begin errors++; $display("FAIL basic_dvd got %0d want 100", bus.div_dividend_o); end
        wait_done(200, cyc, st, gn);
        checks++; if (cyc != 34) begin errors++; $display("FAIL basic_cycle got %0d want 34", cyc); end
        checks++; if (st != 1) begin errors++; $display("FAIL basic_starts got %0d want 1", st); end
        checks++; if (bus.done_o !== 2'b01) begin errors++; $display("FAIL basic_done got %b want 01", bus.done_o); end
        checks++; if (bus.quotient_o !== 32'd14) begin errors++; $display("FAIL basic_quot got %0d want 14", bus.quotient_o); end
        checks++; if (bus.remainder_o !== 32'd2) begin errors++; $display("FAIL basic_rem got %0d want 2", bus.remainder_o); end
        checks++; if (bus.dz_o !== 1'b0) begin errors++; $display("FAIL basic_dz got %b want 0", bus.dz_o); end
        checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL basic_busy_resp got %b want 1", bus.busy_o); end
        tick();
        checks++; if (bus.done_o !== 2'b00) begin errors++; $display("FAIL basic_done_clr got %b want 00", bus.done_o); end
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL basic_idle got %b want 0", bus.busy_o); end
        checks++; if (bus.quotient_o !== 32'd14) begin errors++; $display("FAIL basic_hold got %0d want 14", bus.quotient_o); end
        exp_last = 0;
    endtask

    task automatic test_div_zero;
        int cyc, st, gn;
        bus.dividend_i = {32'd0, 32'd5};
        bus.divisor_i = {32'd0, 32'd0};
        bus.req_i = 2'b01;
        #1;
        checks++; if (bus.gnt_o !== 2'b01) begin errors++; $display("FAIL dz_gnt got %b want 01", bus.gnt_o); end
        tick();
        cyc = 1;
        bus.req_i = '0;
        wait_done(20, cyc, st, gn);
        checks++; if (cyc != 1) begin errors++; $display("FAIL dz_cycle got %0d want 1", cyc); end
        checks++; if (st != 0) begin errors++; $display("FAIL dz_starts got %0d want 0", st); end
        checks++; if (bus.done_o !== 2'b01) begin errors++; $display("FAIL dz_done got %b want 01", bus.done_o); end
        checks++; if (bus.quotient_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_quot got %h want ffffffff", bus.quotient_o); end
        checks++; if (bus.remainder_o !== 32'd5) begin errors++; $display("FAIL dz_rem got %0d want 5", bus.remainder_o); end
        checks++; if (bus.dz_o !== 1'b1) begin errors++; $display("FAIL dz_flag got %b want 1", bus.dz_o); end
        tick();
        checks++; if (bus.div_start_o !== 1'b0) begin errors++; $display("FAIL dz_nostart got %b want 0", bus.div_start_o); end
        exp_last = 0;
        hold_q = 32'hFFFF_FFFF;
    endtask

    task automatic test_alternate;
        int cyc, st, gn, k, exp_cyc;
        logic [31:0] a [NREQ];
        logic [31:0] b [NREQ];
        logic [31:0] eq, er;
        logic edz;
        a[0] = 32'd9; b[0] = 32'd2;
        a[1] = 32'd9; b[1] = 32'd4;
        bus.dividend_i = {a[1], a[0]};
        bus.divisor_i = {b[1], b[0]};
        bus.req_i = 2'b11;
        #1;
        for (int t = 0; t < 8; t++) begin
            k = model_pick(2'b11, exp_last);
            checks++; if (bus.gnt_o !== 2'(1 << k)) begin errors++; $display("FAIL alt_gnt[%0d] got %b want %b", t, bus.gnt_o, 2'(1 << k)); end
            edz = (b[k] == 0);
            eq = edz ? 32'hFFFF_FFFF : a[k] / b[k];
            er = edz ? a[k] : a[k] % b[k];
            stub_lat = $urandom_range(1, 6);
            exp_cyc = edz ? 1 : 2 + stub_lat;
            tick();
            cyc = 1;
            a[k] = $urandom;
            b[k] = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
            bus.dividend_i = {a[1], a[0]};
            bus.divisor_i = {b[1], b[0]};
            wait_done(50, cyc, st, gn);
            checks++; if (cyc != exp_cyc) begin errors++; $display("FAIL alt_cycle[%0d] got %0d want %0d", t, cyc, exp_cyc); end
            checks++; if (bus.done_o !== 2'(1 << k)) begin errors++; $display("FAIL alt_done[%0d] got %b want %b", t, bus.done_o, 2'(1 << k)); end
            checks++; if (bus.quotient_o !== eq) begin errors++; $display("FAIL alt_quot[%0d] got %h want %h", t, bus.quotient_o, eq); end
            checks++; if (bus.remainder_o !== er) begin errors++; $display("FAIL alt_rem[%0d] got %h want %h", t, bus.remainder_o, er); end
            checks++; if (bus.dz_o !== edz) begin errors++; $display("FAIL alt_dz[%0d] got %b want %b", t, bus.dz_o, edz); end
            checks++; if (gn != 0) begin errors++; $display("FAIL alt_busy_gnt[%0d] got %0d want 0", t, gn); end
            exp_last = k;
            hold_q = eq;
            if (t == 7) bus.req_i = '0;
            tick();
        end
    endtask

    task automatic test_late_req;
        int cyc, st, gn;
        stub_lat = 5;
        bus.dividend_i = {32'd0, 32'd20};
        bus.divisor_i = {32'd0, 32'd3};
        bus.req_i = 2'b01;
        #1;
        checks++; if (bus.gnt_o !== 2'(1 << model_pick(2'b01, exp_last))) begin errors++; $display("FAIL late_gnt0 got %b want 01", bus.gnt_o); end
        tick();
        bus.req_i = '0;
        tick();
        cyc = 2;
        bus.dividend_i = {32'd50, 32'd20};
        bus.divisor_i = {32'd6, 32'd3};
        bus.req_i = 2'b10;
        #1;
        checks++; if (bus.quotient_o !== hold_q) begin errors++; $display("FAIL late_quot_stable got %h want %h", bus.quotient_o, hold_q); end
        wait_done(50, cyc, st, gn);
        checks++; if (gn != 0) begin errors++; $display("FAIL late_no_gnt got %0d want 0", gn); end
        checks++; if (cyc != 7) begin errors++; $display("FAIL late_cycle0 got %0d want 7", cyc); end
        checks++; if (bus.quotient_o !== 32'd6) begin errors++; $display("FAIL late_quot0 got %0d want 6", bus.quotient_o); end
        exp_last = 0;
        tick();
        checks++; if (bus.gnt_o !== 2'b10) begin errors++; $display("FAIL late_gnt1 got %b want 10", bus.gnt_o); end
        tick();
        cyc = 1;
        bus.req_i = '0;
        wait_done(50, cyc, st, gn);
        checks++; if (bus.done_o !== 2'b10) begin errors++; $display("FAIL late_done1 got %b want 10", bus.done_o); end
        checks++; if (bus.quotient_o !== 32'd8 || bus.remainder_o !== 32'd2) begin
            errors++; $display("FAIL late_res1 got %0d r %0d want 8 r 2", bus.quotient_o, bus.remainder_o);
        end
        exp_last = 1;
        hold_q = 32'd8;
        tick();
    endtask

    task automatic test_spurious_fini;
        int cyc, st, gn;
        stub_lat = 4;
        stub_spur = 1'b1;
        bus.dividend_i = {32'd0, 32'd77};
        bus.divisor_i = {32'd0, 32'd5};
        bus.req_i = 2'b01;
        #1;
        checks++; if (bus.gnt_o !== 2'(1 << model_pick(2'b01, exp_last))) begin errors++; $display("FAIL spur_gnt got %b want 01", bus.gnt_o); end
        tick();
        cyc = 1;
        bus.req_i = '0;
        wait_done(50, cyc, st, gn);
        stub_spur = 1'b0;
        checks++; if (cyc != 6) begin errors++; $display("FAIL spur_cycle got %0d want 6", cyc); end
        checks++; if (bus.quotient_o !== 32'd15 || bus.remainder_o !== 32'd2) begin
            errors++; $display("FAIL spur_res got %h r %h want 15 r 2", bus.quotient_o, bus.remainder_o);
        end
        exp_last = 0;
        tick();
    endtask

    task automatic test_reset_mid;
        int cyc, st, gn;
        stub_lat = 20;
        bus.dividend_i = {32'd0, 32'd1000};
        bus.divisor_i = {32'd0, 32'd3};
        bus.req_i = 2'b01;
        tick();
        bus.req_i = '0;
        repeat (4) tick();
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.busy_o !== 1'b0 || bus.div_start_o !== 1'b0 || bus.done_o !== 2'b00 || bus.gnt_o !== 2'b00) begin
            errors++; $display("FAIL midrst_ctrl got busy %b start %b done %b gnt %b want 0", bus.busy_o, bus.div_start_o, bus.done_o, bus.gnt_o);
        end
        checks++; if (bus.quotient_o !== 32'd0 || bus.remainder_o !== 32'd0 || bus.dz_o !== 1'b0) begin
            errors++; $display("FAIL midrst_res got %h r %h dz %b want 0", bus.quotient_o, bus.remainder_o, bus.dz_o);
        end
        checks++; if (bus.div_dividend_o !== 32'd0 || bus.div_divisor_o !== 32'd0) begin
            errors++; $display("FAIL midrst_ops got %h / %h want 0", bus.div_dividend_o, bus.div_divisor_o);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_last = NREQ - 1;
        tick();
        stub_lat = 3;
        bus.dividend_i = {32'd10, 32'hFFFF_FFFF};
        bus.divisor_i = {32'd3, 32'd1};
        bus.req_i = 2'b11;
        #1;
        checks++; if (bus.gnt_o !== 2'(1 << model_pick(2'b11, exp_last))) begin errors++; $display("FAIL midrst_gnt got %b want 01", bus.gnt_o); end
        tick();
        cyc = 1;
        bus.req_i = '0;
        wait_done(50, cyc, st, gn);
        checks++; if (cyc != 5 || bus.done_o !== 2'b01) begin errors++; $display("FAIL midrst_done got cyc %0d done %b want 5 01", cyc, bus.done_o); end
        checks++; if (bus.quotient_o !== 32'hFFFF_FFFF || bus.remainder_o !== 32'd0) begin
            errors++; $display("FAIL midrst_res2 got %h r %h want ffffffff r 0", bus.quotient_o, bus.remainder_o);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_alternate();
        test_late_req();
        test_spurious_fini();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
